// File: rtl/rate_tick_pkg.sv
// Shared definitions for the multi-rate timebase: half-period table math and rate index type.
package rate_tick_pkg;

    localparam int MIN_HALF_PERIOD = 1;
    localparam int RATE_NUM_DEFAULT = 4;

    typedef logic [$clog2(RATE_NUM_DEFAULT)-1:0] rate_idx_t;

    // Truncating half-period, in input clock cycles, of rate index idx.
    function automatic int half_period(input int f_input, input int f_base, input int idx);
        return f_input / (2 * (f_base << idx));
    endfunction

endpackage

// File: rtl/rate_half_lut.sv
// Combinational lookup of the terminal count (half-period minus one) for the latched rate.
module rate_half_lut
    import rate_tick_pkg::*;
#(
    parameter int F_INPUT   = 50_000_000,
    parameter int F_BASE    = 1,
    parameter int NUM_RATES = 4,
    parameter int CNT_W     = 1
) (
    input  logic [$clog2(NUM_RATES)-1:0] i_idx,
    output logic [CNT_W-1:0]             o_term
);

    localparam int IDX_W = $clog2(NUM_RATES);

    always_comb begin
        o_term = '0;
        for (int i = 0; i < NUM_RATES; i++) begin
            if (i_idx == IDX_W'(i)) begin
                o_term = CNT_W'(half_period(F_INPUT, F_BASE, i) - 1);
            end
        end
    end

endmodule

// File: rtl/rate_tick_gen.sv
// Multi-rate tick/square-wave timebase with pause, single-step and phase restart.
// Define RATE_SQUARE_OUT_EN to drive clk_out from the internal phase; otherwise clk_out is 0.
module rate_tick_gen
    import rate_tick_pkg::*;
#(
    parameter int F_INPUT   = 50_000_000,
    parameter int F_BASE    = 1,
    parameter int NUM_RATES = 4
) (
    input  logic                         clk_in,
    input  logic                         reset,
    input  logic [$clog2(NUM_RATES)-1:0] rate_sel,
    input  logic                         pause,
    input  logic                         step,
    input  logic                         restart,
    output logic                         tick,
    output logic                         clk_out,
    output logic [$clog2(NUM_RATES)-1:0] active_rate
);

    localparam int IDX_W = $clog2(NUM_RATES);
    localparam int HALF0 = half_period(F_INPUT, F_BASE, 0);
    localparam int CNT_W = (HALF0 > 1) ? $clog2(HALF0) : 1;
    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(NUM_RATES - 1);

    if (NUM_RATES < 2) begin : g_num_rates_chk
        $error("rate_tick_gen: NUM_RATES must be at least 2");
    end
    if (half_period(F_INPUT, F_BASE, NUM_RATES - 1) < MIN_HALF_PERIOD) begin : g_half_chk
        $error("rate_tick_gen: fastest rate has a half-period below one input cycle");
    end

    logic [CNT_W-1:0] r_cnt;
    logic             r_phase;
    logic             r_tick;
    logic [IDX_W-1:0] r_act;
    logic [CNT_W-1:0] w_term;
    logic [IDX_W-1:0] w_sel_clamped;

    assign w_sel_clamped = (rate_sel > MAX_IDX) ? MAX_IDX : rate_sel;

    rate_half_lut #(
        .F_INPUT   (F_INPUT),
        .F_BASE    (F_BASE),
        .NUM_RATES (NUM_RATES),
        .CNT_W     (CNT_W)
    ) u_half_lut (
        .i_idx  (r_act),
        .o_term (w_term)
    );

    // Restart beats pause/step; rate_sel is only sampled at restart or the end of a period.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
            r_tick  <= 1'b0;
            r_act   <= '0;
        end else begin
            r_tick <= 1'b0;
            if (restart) begin
                r_cnt   <= '0;
                r_phase <= 1'b0;
                r_act   <= w_sel_clamped;
            end else if (pause) begin
                r_tick <= step;
            end else if (r_cnt == w_term) begin
                r_cnt   <= '0;
                r_phase <= ~r_phase;
                if (!r_phase) begin
                    r_tick <= 1'b1;
                end else begin
                    r_act <= w_sel_clamped;
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign tick        = r_tick;
    assign active_rate = r_act;

`ifdef RATE_SQUARE_OUT_EN
    assign clk_out = r_phase;
`else
    assign clk_out = 1'b0;
`endif

endmodule

// File: tb/tb_rate_tick_gen.sv
// Scoreboard bench for rate_tick_gen with HALF = 40/20/10 (F_INPUT=80, F_BASE=1, NUM_RATES=3).
module tb_rate_tick_gen;

    localparam int F_INPUT   = 80;
    localparam int F_BASE    = 1;
    localparam int NUM_RATES = 3;
`ifdef RATE_SQUARE_OUT_EN
    localparam bit SQ = 1'b1;
`else
    localparam bit SQ = 1'b0;
`endif

    logic       clk_in   = 1'b0;
    logic       reset    = 1'b0;
    logic [1:0] rate_sel = 2'd0;
    logic       pause    = 1'b0;
    logic       step     = 1'b0;
    logic       restart  = 1'b0;
    logic       tick;
    logic       clk_out;
    logic [1:0] active_rate;

    int cyc   = 0;
    int n_cmp = 0;
    int n_err = 0;
    int base  = 0;
    int exp_q[$];
    int exp_t;

    rate_tick_gen #(
        .F_INPUT   (F_INPUT),
        .F_BASE    (F_BASE),
        .NUM_RATES (NUM_RATES)
    ) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .rate_sel    (rate_sel),
        .pause       (pause),
        .step        (step),
        .restart     (restart),
        .tick        (tick),
        .clk_out     (clk_out),
        .active_rate (active_rate)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Every observed tick must match the next scheduled cycle in the scoreboard.
    always @(negedge clk_in) begin
        if (tick === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL tick_unexpected: tick at cycle %0d, required no tick", cyc);
            end else begin
                exp_t = exp_q.pop_front();
                if (cyc !== exp_t) begin
                    n_err++;
                    $display("FAIL tick_time: tick at cycle %0d, required cycle %0d", cyc, exp_t);
                end
            end
        end
    end

    task automatic test_reset();
        repeat (3) @(negedge clk_in);
        n_cmp++;
        if (tick !== 1'b0) begin
            n_err++; $display("FAIL reset_tick: got %0b required 0", tick);
        end
        n_cmp++;
        if (clk_out !== 1'b0) begin
            n_err++; $display("FAIL reset_clk_out: got %0b required 0", clk_out);
        end
        n_cmp++;
        if (active_rate !== 2'd0) begin
            n_err++; $display("FAIL reset_active_rate: got %0d required 0", active_rate);
        end
    endtask

    task automatic test_rate0_run();
        int k;
        logic ph;
        rate_sel = 2'd0;
        @(negedge clk_in);
        reset = 1'b1;
        base  = cyc;
        for (int i = 40; i <= 200; i += 80) exp_q.push_back(base + i);
        while (cyc < base + 210) begin
            @(negedge clk_in);
            k  = cyc - base;
            ph = ((k / 40) % 2) == 1;
            n_cmp++;
            if (clk_out !== (SQ ? ph : 1'b0)) begin
                n_err++; $display("FAIL rate0_clk_out: k=%0d got %0b required %0b", k, clk_out, SQ ? ph : 1'b0);
            end
            n_cmp++;
            if (active_rate !== 2'd0) begin
                n_err++; $display("FAIL rate0_active_rate: k=%0d got %0d required 0", k, active_rate);
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL rate0_missing_ticks: %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_restart_rate2();
        int k;
        logic ph;
        rate_sel = 2'd2;
        restart  = 1'b1;
        @(negedge clk_in);
        restart = 1'b0;
        base    = cyc;
        n_cmp++;
        if (active_rate !== 2'd2) begin
            n_err++; $display("FAIL restart_active_rate: got %0d required 2", active_rate);
        end
        n_cmp++;
        if (tick !== 1'b0) begin
            n_err++; $display("FAIL restart_tick: got %0b required 0", tick);
        end
        for (int i = 10; i <= 50; i += 20) exp_q.push_back(base + i);
        while (cyc < base + 52) begin
            @(negedge clk_in);
            k  = cyc - base;
            ph = ((k / 10) % 2) == 1;
            n_cmp++;
            if (clk_out !== (SQ ? ph : 1'b0)) begin
                n_err++; $display("FAIL rate2_clk_out: k=%0d got %0b required %0b", k, clk_out, SQ ? ph : 1'b0);
            end
            n_cmp++;
            if (active_rate !== 2'd2) begin
                n_err++; $display("FAIL rate2_active_rate: k=%0d got %0d required 2", k, active_rate);
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL rate2_missing_ticks: %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_rate_change();
        int k;
        logic ph;
        logic [1:0] ar;
        rate_sel = 2'd1;
        exp_q.push_back(base + 80);
        exp_q.push_back(base + 120);
        while (cyc < base + 130) begin
            @(negedge clk_in);
            k  = cyc - base;
            ph = (k < 60) ? (((k / 10) % 2) == 1) : ((((k - 60) / 20) % 2) == 1);
            ar = (k < 60) ? 2'd2 : 2'd1;
            n_cmp++;
            if (clk_out !== (SQ ? ph : 1'b0)) begin
                n_err++; $display("FAIL change_clk_out: k=%0d got %0b required %0b", k, clk_out, SQ ? ph : 1'b0);
            end
            n_cmp++;
            if (active_rate !== ar) begin
                n_err++; $display("FAIL change_active_rate: k=%0d got %0d required %0d", k, active_rate, ar);
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL change_missing_ticks: %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_pause_step();
        int k;
        int kk;
        logic ph;
        pause = 1'b1;
        exp_q.push_back(base + 134);
        exp_q.push_back(base + 167);
        while (cyc < base + 170) begin
            @(negedge clk_in);
            k = cyc - base;
            if (k == 133) step = 1'b1;
            if (k == 134) step = 1'b0;
            if (k == 137) pause = 1'b0;
            if (k == 150) step = 1'b1;
            if (k == 151) step = 1'b0;
            kk = (k > 137) ? k - 7 : k;
            ph = (((kk - 60) / 20) % 2) == 1;
            n_cmp++;
            if (clk_out !== (SQ ? ph : 1'b0)) begin
                n_err++; $display("FAIL pause_clk_out: k=%0d got %0b required %0b", k, clk_out, SQ ? ph : 1'b0);
            end
            n_cmp++;
            if (active_rate !== 2'd1) begin
                n_err++; $display("FAIL pause_active_rate: k=%0d got %0d required 1", k, active_rate);
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL pause_missing_ticks: %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_restart_on_terminal();
        int k;
        logic ph;
        exp_q.push_back(base + 227);
        while (cyc < base + 230) begin
            @(negedge clk_in);
            k = cyc - base;
            if (k == 206) restart = 1'b1;
            if (k == 207) begin
                restart = 1'b0;
                n_cmp++;
                if (tick !== 1'b0) begin
                    n_err++; $display("FAIL term_restart_tick: got %0b required 0", tick);
                end
            end
            ph = (k < 207) ? (((k - 67) / 20) % 2) == 1 : (((k - 207) / 20) % 2) == 1;
            n_cmp++;
            if (clk_out !== (SQ ? ph : 1'b0)) begin
                n_err++; $display("FAIL term_clk_out: k=%0d got %0b required %0b", k, clk_out, SQ ? ph : 1'b0);
            end
            n_cmp++;
            if (active_rate !== 2'd1) begin
                n_err++; $display("FAIL term_active_rate: k=%0d got %0d required 1", k, active_rate);
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL term_missing_ticks: %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_clamp_and_async_reset();
        int k;
        logic ph;
        logic [1:0] ar;
        exp_q.push_back(base + 257);
        exp_q.push_back(base + 277);
        while (cyc < base + 282) begin
            @(negedge clk_in);
            k = cyc - base;
            if (k == 237) rate_sel = 2'd3;
            ph = (k < 247) ? (((k - 207) / 20) % 2) == 1 : (((k - 247) / 10) % 2) == 1;
            ar = (k < 247) ? 2'd1 : 2'd2;
            n_cmp++;
            if (clk_out !== (SQ ? ph : 1'b0)) begin
                n_err++; $display("FAIL clamp_clk_out: k=%0d got %0b required %0b", k, clk_out, SQ ? ph : 1'b0);
            end
            n_cmp++;
            if (active_rate !== ar) begin
                n_err++; $display("FAIL clamp_active_rate: k=%0d got %0d required %0d", k, active_rate, ar);
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL clamp_missing_ticks: %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (clk_out !== 1'b0) begin
            n_err++; $display("FAIL async_reset_clk_out: got %0b required 0", clk_out);
        end
        n_cmp++;
        if (active_rate !== 2'd0) begin
            n_err++; $display("FAIL async_reset_active_rate: got %0d required 0", active_rate);
        end
        n_cmp++;
        if (tick !== 1'b0) begin
            n_err++; $display("FAIL async_reset_tick: got %0b required 0", tick);
        end
        repeat (3) @(negedge clk_in);
        reset = 1'b1;
        base  = cyc;
        exp_q.push_back(base + 40);
        while (cyc < base + 85) begin
            @(negedge clk_in);
            k  = cyc - base;
            ph = (k < 80) ? (((k / 40) % 2) == 1) : 1'b0;
            ar = (k < 80) ? 2'd0 : 2'd2;
            n_cmp++;
            if (clk_out !== (SQ ? ph : 1'b0)) begin
                n_err++; $display("FAIL post_reset_clk_out: k=%0d got %0b required %0b", k, clk_out, SQ ? ph : 1'b0);
            end
            n_cmp++;
            if (active_rate !== ar) begin
                n_err++; $display("FAIL post_reset_active_rate: k=%0d got %0d required %0d", k, active_rate, ar);
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL post_reset_missing_ticks: %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_rate0_run();
        test_restart_rate2();
        test_rate_change();
        test_pause_step();
        test_restart_on_terminal();
        test_clamp_and_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rate_tick_gen.md
# rate_tick_gen

Multi-rate timebase for the message-display path. It derives a one-cycle `tick` enable and an optional 50 % square `clk_out` from `clk_in`, at one of `NUM_RATES` binary-scaled rates selected at run time. Rate changes take effect only at period boundaries, so the output never glitches. It also supports pause, single-step and synchronous restart. The scroller consumes `tick` as a clock enable; `clk_out` is kept for LED and debug use and is never a functional clock.

## Interface
- `F_INPUT`, 50_000_000: input clock frequency in Hz.
- `F_BASE`, 1: slowest rate in Hz (rate index 0).
- `NUM_RATES`, 4: number of selectable rates; rate `i` = `F_BASE << i`; minimum 2.

- `clk_in`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `rate_sel`  in  `$clog2(NUM_RATES)`  requested rate index; values ≥ `NUM_RATES` clamp to `NUM_RATES-1`.
- `pause`  in  1  level; freezes the timebase.
- `step`  in  1  pulse; one manual tick while paused.
- `restart`  in  1  pulse; synchronous phase restart.
- `tick`  out  1  registered one-cycle pulse, once per period.
- `clk_out`  out  1  registered square wave at the active rate.
- `active_rate`  out  `$clog2(NUM_RATES)`  rate index currently in force.

## Operation
- Half-period table: `HALF[i] = F_INPUT / (2*(F_BASE<<i))`, using truncating integer division.
- Elaboration error if `HALF[NUM_RATES-1] < 1`.
- Internal state:
  - `cnt`, width `$clog2(HALF[0])`, minimum 1 bit.
  - `phase`, 1 bit, drives `clk_out`.
  - `act`, the latched rate index, drives `active_rate`.
- Normal run (`pause`=0):
  - `cnt` increments each cycle.
  - When `cnt == HALF[act]-1`: `cnt` ← 0 and `phase` toggles.
  - On the 0→1 toggle: `tick` ← 1 for one cycle.
  - On the 1→0 toggle (end of period): `act` ← clamped `rate_sel`.
- `rate_sel` is not sampled at any other time. A change mid-period completes the current period at the old rate.
- Pause: `cnt`, `phase` and `act` hold. `tick` = 0 except for a step.
- Step: `step`=1 with `pause`=1 gives `tick`=1 on the next cycle and leaves counter state untouched. `step` while running is ignored.
- Restart (highest priority, overrides `pause` and `step`): `cnt` ← 0, `phase` ← 0, `tick` ← 0, `act` ← clamped `rate_sel`.
- Reset (async, `reset`=0): `cnt`=0, `phase`=0, `tick`=0, `clk_out`=0, `act`=0, `active_rate`=0. After reset, the first period always runs at rate 0 unless restarted.

## Timing
- All outputs are registered; no combinational input→output path.
- With `act`=a and H=`HALF[a]`, after reset release or a restart cycle:
  - `tick` is high in the cycle following the H-th rising edge.
  - `clk_out` rises in that same cycle.
  - Subsequent ticks arrive every 2H cycles; `clk_out` is high H cycles and low H cycles.
- The new `act` is visible on `active_rate` in the cycle after the end-of-period toggle. The next period uses the new half-period.
- Pause asserted for P cycles delays every later edge by exactly P cycles.
- `step` and the terminal count cannot coincide, because a step requires `pause` and the counter is frozen during pause.
- `restart` and the terminal count in the same cycle: restart wins; no tick; `phase` goes to 0.

## Configuration
- `RATE_SQUARE_OUT_EN`:
  - Defined: `clk_out` is driven from `phase` as above.
  - Undefined: `clk_out` is tied to 0. `phase` is still kept internally, because `tick` and the rate latch depend on it.
- `tick` behaviour is identical in both builds.

## Structure
- Package `rate_tick_pkg` holds:
  - function `half_period(f_input, f_base, idx)` returning int;
  - typedef `rate_idx_t` sized from `NUM_RATES`;
  - localparam for the minimum legal half-period (1).
- Sub-module `rate_half_lut`: combinational lookup of `HALF[act]-1` from the elaborated table, feeding the compare. Everything else is one `always_ff` block in `rate_tick_gen`.

## Test plan
All scenarios use `F_INPUT`=80, `F_BASE`=1, `NUM_RATES`=3, giving HALF = 40/20/10.
- Reset release, `rate_sel`=0 → first `tick` after the 40th edge, then every 80 cycles; `clk_out` high 40 / low 40; `active_rate`=0.
- Restart with `rate_sel`=2 → `active_rate`=2 next cycle; ticks every 20 cycles; first tick 10 edges after restart.
- Change `rate_sel` 2→1 mid-high-phase → the current period completes at 20 cycles; the next period is 40 cycles; `active_rate` updates right after the falling `clk_out` edge.
- `pause` for 7 cycles, with a `step` during the pause → exactly one extra `tick` one cycle after `step`; later natural edges shift by 7 cycles.
- `restart` asserted on a terminal-count cycle → no tick; `clk_out`=0; counting restarts from 0.
- `rate_sel`=3 (out of range) at a boundary → clamps to 2; `reset` asserted mid-period → all outputs 0 immediately (asynchronously).
